// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the pipeline memory stage and the data memory.
// The stage is the master: it raises req and holds the request fields stable
// until the memory answers with ready (and rdata for reads).
interface mem_access_stage_if #(
  parameter int AW = 30
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          ready;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RISC-V pipeline.
// Takes the EX/MEM register contents, performs loads/stores over a req/ready
// data-memory handshake, stalls the front of the pipe while an access is in
// flight, and registers the aligned/extended result into MEM/WB.
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// (no request, one-cycle misalign_exc pulse, bubble into MEM/WB). Without it,
// misaligned addresses are silently aligned and misalign_exc is tied low.
module mem_access_stage #(
  parameter int DMEM_AW = 30
) (
  input  logic                clk,
  input  logic                rst,
  // EX/MEM register outputs
  input  logic [31:0]         result_in,
  input  logic [31:0]         rd_data_2_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                mem_to_reg_in,
  input  logic                reg_write_in,
  input  logic [4:0]          rd_in,
  input  logic [2:0]          func3_in,
  // data memory
  mem_access_stage_if.master  dmem,
  // pipeline control
  output logic                mem_stall,
  // MEM/WB register
  output logic [31:0]         wb_data_out,
  output logic [4:0]          wb_rd_out,
  output logic                wb_reg_write_out,
  output logic                misalign_exc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [0:0]  state;

  // decoded view of the incoming EX/MEM instruction
  logic        access;
  logic        is_store;
  logic        is_word;
  logic        is_half;
  logic        trap;
  logic [31:0] eff_addr;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // instruction context captured when the request is launched
  logic [2:0]  lat_func3;
  logic [1:0]  lat_lane;
  logic [4:0]  lat_rd;
  logic        lat_mem_to_reg;
  logic        lat_reg_write;
  logic [31:0] lat_result;

  // load data after lane selection and extension
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  // Decode access type and compute the size-aligned byte address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    access   = mem_read_in | mem_write_in;
    is_store = mem_write_in;
    is_word  = (func3_in == F3_W);
    is_half  = (func3_in == F3_H) || (!is_store && (func3_in == F3_HU));
    eff_addr = result_in;
    if (is_word) begin
      eff_addr[1:0] = 2'b00;
    end else if (is_half) begin
      eff_addr[0] = 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned word or half-word access is trapped instead of issued.
  assign trap = access &&
                ((is_word && (result_in[1:0] != 2'b00)) ||
                 (is_half && result_in[0]));
`else
  assign trap = 1'b0;
`endif

  // Byte enables by access size and lane-replicated store data.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = rd_data_2_in;
    case (func3_in[1:0])
      2'b00: begin
        be_next    = 4'b0001 << eff_addr[1:0];
        wdata_next = {4{rd_data_2_in[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {eff_addr[1], 1'b0};
        wdata_next = {2{rd_data_2_in[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = rd_data_2_in;
      end
    endcase
  end

  // Stall while an issued access is pending; the cycle the memory answers
  // lets the upstream registers advance.
  assign mem_stall = (state == ST_IDLE) ? (access && !trap) : !dmem.ready;

  // Select the addressed lane and sign/zero-extend the load data.
  always_comb begin
    lane_byte = 8'h00;
    lane_half = lat_lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (lat_lane)
      2'd0:    lane_byte = dmem.rdata[7:0];
      2'd1:    lane_byte = dmem.rdata[15:8];
      2'd2:    lane_byte = dmem.rdata[23:16];
      default: lane_byte = dmem.rdata[31:24];
    endcase
    case (lat_func3)
      F3_B:    load_fmt = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_fmt = {{16{lane_half[15]}}, lane_half};
      F3_W:    load_fmt = dmem.rdata;
      F3_BU:   load_fmt = {24'h000000, lane_byte};
      F3_HU:   load_fmt = {16'h0000, lane_half};
      default: load_fmt = dmem.rdata;
    endcase
  end

  // Handshake FSM: launch the request from IDLE, release it on ready.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= 4'b0000;
      dmem.wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !trap) begin
            state      <= ST_WAIT;
            dmem.req   <= 1'b1;
            dmem.we    <= is_store;
            dmem.addr  <= eff_addr[DMEM_AW+1:2];
            dmem.be    <= be_next;
            dmem.wdata <= wdata_next;
          end
        end
        ST_WAIT: begin
          if (dmem.ready) begin
            state    <= ST_IDLE;
            dmem.req <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          dmem.req <= 1'b0;
        end
      endcase
    end
  end

  // Capture the instruction context when the request is launched.
  always_ff @(posedge clk) begin
    // NOTE: context registers carry no reset; they are only read in WAIT, after being loaded on entry.
    if (state == ST_IDLE && access && !trap) begin
      lat_func3      <= func3_in;
      lat_lane       <= eff_addr[1:0];
      lat_rd         <= rd_in;
      lat_mem_to_reg <= mem_to_reg_in && !is_store;
      lat_reg_write  <= reg_write_in && !is_store;
      lat_result     <= result_in;
    end
  end

  // MEM/WB register: pass-through, bubble while busy, or the completed access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_out      <= 32'h0;
      wb_rd_out        <= 5'd0;
      wb_reg_write_out <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (!access) begin
        wb_data_out      <= result_in;
        wb_rd_out        <= rd_in;
        wb_reg_write_out <= reg_write_in;
      end else begin
        wb_data_out      <= 32'h0;
        wb_rd_out        <= 5'd0;
        wb_reg_write_out <= 1'b0;
      end
    end else if (dmem.ready) begin
      wb_data_out      <= lat_mem_to_reg ? load_fmt : lat_result;
      wb_rd_out        <= lat_rd;
      wb_reg_write_out <= lat_reg_write;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle exception pulse for a trapped access seen in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= (state == ST_IDLE) && trap;
    end
  end
`else
  assign misalign_exc = 1'b0;
`endif

endmodule
